// File: rtl/popcount_seq_ctrl.sv
// popcount_seq_ctrl: sequences a ternary neuron through a shared 11-bit popcount unit
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          operand handshake; ready only while idle
//   x, w_pos, w_neg            activations and +1/-1 weight masks, 11*NCH bits each
//   th_hi, th_lo               signed 7-bit thresholds
//   pc_in/pc_en/pc_out         chunk operand, consume strobe and result of the external popcount11
//   out_valid/out_ready, y     result handshake; y = 01 (+1), 11 (-1), 00 (0)
// Build option: define POPCOUNT_SEQ_GATE_EN to skip chunks whose weight slice is all zero.
module popcount_seq_ctrl #(
  parameter int NCH = 3,
  localparam int W = 11 * NCH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      w_pos,
  input  logic [W-1:0]      w_neg,
  input  logic signed [6:0] th_hi,
  input  logic signed [6:0] th_lo,
  output logic [10:0]       pc_in,
  output logic              pc_en,
  input  logic [3:0]        pc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        y
);
  typedef enum logic [2:0] {S_IDLE, S_POS, S_NEG, S_CMP, S_DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] acc_pos_q, acc_pos_d, acc_neg_q, acc_neg_d;
  logic [W-1:0] x_q, x_d, wp_q, wp_d, wn_q, wn_d;
  logic signed [6:0] th_hi_q, th_hi_d, th_lo_q, th_lo_d;
  logic [1:0] y_q, y_d;
  logic [10:0] x_c, wp_c, wn_c, mask_c;
  logic act, gate, last;
  logic signed [6:0] d;
  always_comb begin
    x_c = '0;
    wp_c = '0;
    wn_c = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cnt_q == 2'(k)) begin
        x_c = x_q[11*k +: 11];
        wp_c = wp_q[11*k +: 11];
        wn_c = wn_q[11*k +: 11];
      end
    end
  end
  assign mask_c = (state_q == S_NEG) ? wn_c : wp_c;
  assign act = (state_q == S_POS) || (state_q == S_NEG);
`ifdef POPCOUNT_SEQ_GATE_EN
  // An all-zero weight slice cannot contribute, so the popcount unit is left idle.
  assign gate = (mask_c == '0);
`else
  assign gate = 1'b0;
`endif
  assign pc_en = act && !gate;
  assign pc_in = pc_en ? (x_c & mask_c) : '0;
  assign last = (cnt_q == 2'(NCH - 1));
  // Accumulators are at most 60, so the zero-extended difference fits 7-bit signed.
  assign d = $signed({1'b0, acc_pos_q}) - $signed({1'b0, acc_neg_q});
  assign in_ready = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y = y_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_pos_d = acc_pos_q;
    acc_neg_d = acc_neg_q;
    x_d = x_q;
    wp_d = wp_q;
    wn_d = wn_q;
    th_hi_d = th_hi_q;
    th_lo_d = th_lo_q;
    y_d = y_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        x_d = x;
        wp_d = w_pos;
        wn_d = w_neg;
        th_hi_d = th_hi;
        th_lo_d = th_lo;
        cnt_d = '0;
        acc_pos_d = '0;
        acc_neg_d = '0;
        state_d = S_POS;
      end
      S_POS: begin
        acc_pos_d = pc_en ? acc_pos_q + {2'b00, pc_out} : acc_pos_q;
        cnt_d = last ? 2'd0 : cnt_q + 2'd1;
        state_d = last ? S_NEG : S_POS;
      end
      S_NEG: begin
        acc_neg_d = pc_en ? acc_neg_q + {2'b00, pc_out} : acc_neg_q;
        cnt_d = last ? 2'd0 : cnt_q + 2'd1;
        state_d = last ? S_CMP : S_NEG;
      end
      S_CMP: begin
        y_d = (d >= th_hi_q) ? 2'b01 : (d <= th_lo_q) ? 2'b11 : 2'b00;
        state_d = S_DONE;
      end
      S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      acc_pos_q <= '0;
      acc_neg_q <= '0;
      x_q <= '0;
      wp_q <= '0;
      wn_q <= '0;
      th_hi_q <= '0;
      th_lo_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_pos_q <= acc_pos_d;
      acc_neg_q <= acc_neg_d;
      x_q <= x_d;
      wp_q <= wp_d;
      wn_q <= wn_d;
      th_hi_q <= th_hi_d;
      th_lo_q <= th_lo_d;
      y_q <= y_d;
    end
  end
endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// tb_popcount_seq_ctrl: directed table, corner sequences and random vectors against a count-based model
module tb_popcount_seq_ctrl;
  localparam int NCH = 3;
  localparam int W = 11 * NCH;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] x = '0, w_pos = '0, w_neg = '0;
  logic signed [6:0] th_hi = '0, th_lo = '0;
  logic in_ready, pc_en, out_valid;
  logic [10:0] pc_in;
  logic [3:0] pc_out;
  logic [1:0] y;
  int checks = 0;
  int errors = 0;
  popcount_seq_ctrl #(.NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w_pos(w_pos), .w_neg(w_neg), .th_hi(th_hi), .th_lo(th_lo),
    .pc_in(pc_in), .pc_en(pc_en), .pc_out(pc_out),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );
  assign pc_out = 4'($countones(pc_in));
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] wp;
    logic [W-1:0] wn;
    logic signed [6:0] hi;
    logic signed [6:0] lo;
    logic [1:0] y;
  } vec_t;
  localparam logic [W-1:0] ALL = '1;
  localparam logic [W-1:0] Z = '0;
  localparam logic [W-1:0] WP1 = {11'h7FF, 11'h000, 11'h7FF};
  vec_t tbl[12];
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [10:0] chunk(logic [W-1:0] v, int k);
    return v[11*k +: 11];
  endfunction
  function automatic logic [1:0] ref_y(vec_t v);
    int d, hi, lo;
    d = $countones(v.x & v.wp) - $countones(v.x & v.wn);
    hi = v.hi;
    lo = v.lo;
    if (d >= hi) return 2'b01;
    if (d <= lo) return 2'b11;
    return 2'b00;
  endfunction
  function automatic logic gate_en(logic [W-1:0] m, int k);
    logic nz;
    nz = chunk(m, k) != '0;
`ifdef POPCOUNT_SEQ_GATE_EN
    return nz;
`else
    return nz || 1'b1;
`endif
  endfunction
  task automatic apply(vec_t v);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    x = v.x;
    w_pos = v.wp;
    w_neg = v.wn;
    th_hi = v.hi;
    th_lo = v.lo;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic track(vec_t v, string nm);
    for (int c = 0; c < 2 * NCH + 1; c++) begin
      logic [W-1:0] m;
      int k;
      logic en;
      m = (c < NCH) ? v.wp : v.wn;
      k = c % NCH;
      en = (c < 2 * NCH) && gate_en(m, k);
      chk({nm, "_busy"}, {in_ready, out_valid}, 0);
      chk({nm, "_pc_en"}, pc_en, en);
      chk({nm, "_pc_in"}, pc_in, en ? (chunk(v.x, k) & chunk(m, k)) : 11'd0);
      @(posedge clk);
      #1;
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_y"}, y, v.y);
  endtask
  task automatic handshake(string nm);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({nm, "_valid_fall"}, out_valid, 0);
    chk({nm, "_ready_back"}, in_ready, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    int dly, k;
    tbl[0] = '{ALL, ALL, Z, 7'sd10, -7'sd10, 2'b01};
    tbl[1] = '{ALL, Z, ALL, 7'sd10, -7'sd10, 2'b11};
    tbl[2] = '{ALL, Z, ALL, -7'sd40, -7'sd10, 2'b01};
    tbl[3] = '{ALL, ALL, Z, 7'sd33, 7'sd0, 2'b01};
    tbl[4] = '{ALL, ALL, Z, 7'sd34, 7'sd33, 2'b11};
    tbl[5] = '{ALL, ALL, Z, 7'sd34, 7'sd32, 2'b00};
    tbl[6] = '{ALL, Z, Z, 7'sd1, -7'sd1, 2'b00};
    tbl[7] = '{Z, ALL, ALL, 7'sd0, 7'sd0, 2'b01};
    tbl[8] = '{ALL, WP1, Z, 7'sd22, 7'sd21, 2'b01};
    tbl[9] = '{ALL, WP1, Z, 7'sd23, 7'sd21, 2'b00};
    tbl[10] = '{ALL, ALL, ALL, 7'sd63, 7'h40, 2'b00};
    tbl[11] = '{ALL, WP1, ALL, -7'sd11, -7'sd12, 2'b01};
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_pc_in", pc_in, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i]);
      track(tbl[i], $sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end
    apply(tbl[0]);
    track(tbl[0], "bp_a");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      x = ALL;
      w_pos = Z;
      w_neg = ALL;
      th_hi = 7'sd10;
      th_lo = -7'sd10;
      @(posedge clk);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_y", y, 2'b01);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    track(tbl[1], "bp_b");
    handshake("bp_b");
    apply(tbl[1]);
    @(posedge clk);
    #1 chk("abort_in_pos", pc_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_y", y, 0);
    chk("abort_pc_en", pc_en, 0);
    chk("abort_pc_in", pc_in, 0);
    @(negedge clk) rst_n = 1'b1;
    v = '{ALL, ALL, Z, 7'sd0, 7'sd0, 2'b01};
    apply(v);
    track(v, "after_abort");
    handshake("after_abort");
    for (int i = 0; i < 40; i++) begin
      v.x = W'({$urandom(), $urandom()});
      v.wp = W'({$urandom(), $urandom()});
      v.wn = W'({$urandom(), $urandom()}) & ~v.wp;
      if ($urandom_range(0, 3) == 0) begin
        k = int'($urandom_range(0, NCH - 1));
        v.wp[11*k +: 11] = '0;
      end
      v.hi = 7'(int'($urandom_range(0, 60)) - 30);
      v.lo = 7'(int'(v.hi) - int'($urandom_range(0, 20)));
      v.y = ref_y(v);
      apply(v);
      track(v, $sformatf("rnd%0d", i));
      dly = int'($urandom_range(0, 3));
      for (int j = 0; j < dly; j++) begin
        @(posedge clk);
        #1;
        chk("rnd_hold_valid", out_valid, 1);
        chk("rnd_hold_y", y, v.y);
      end
      handshake($sformatf("rnd%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
